// File: rtl/Pollparametr.sv
// Shared parameters for the multiply-add pipeline and its downstream stages.
package Pollparametr;

  localparam int unsigned Const      = 8;
  localparam int unsigned MACW_IN_W  = 2 * Const;
  localparam int unsigned MACW_ACC_W = MACW_IN_W + 2;

  typedef logic [MACW_ACC_W-1:0] macw_acc_t;

endpackage

// File: rtl/sat_add_u.sv
// Unsigned saturating adder: accumulator plus zero-extended narrower operand.
module sat_add_u #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 18
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] ext_sum;

  // One spare bit catches the carry; it doubles as the overflow flag.
  assign ext_sum = {1'b0, a} + (ACC_W+1)'(b);
  assign ovf     = ext_sum[ACC_W];
  assign sum     = ovf ? {ACC_W{1'b1}} : ext_sum[ACC_W-1:0];

endmodule

// File: rtl/mac_window_accum.sv
// Sums WINDOW multiply-add results into one saturating total and presents it
// on a valid/ready port; stalls upstream only when a finished total has no room.
module mac_window_accum
  import Pollparametr::*;
#(
  parameter int unsigned IN_W   = MACW_IN_W,
  parameter int unsigned WINDOW = 8,
  parameter int unsigned ACC_W  = IN_W + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             out_sat_q, out_sat_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             last_c;
  logic             accept_c;
  logic             complete_c;

  sat_add_u #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign last_c     = (cnt_q == CNT_LAST);
  assign in_ready   = !(last_c && out_valid_q && !out_ready);
  assign accept_c   = in_valid && in_ready;
  assign complete_c = accept_c && last_c && !clr;

  // Window accumulation; clr wins over a sample in the same cycle.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (accept_c) begin
      if (last_c) begin
        acc_d = '0;
        cnt_d = '0;
        sat_d = 1'b0;
      end else begin
        acc_d = add_sum;
        cnt_d = cnt_q + CNT_W'(1);
        sat_d = sat_q | add_ovf;
      end
    end
  end

  // Output holding register; a new total may replace one taken this cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    if (complete_c) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_sat_d   = sat_q | add_ovf;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_window_accum.sv
// Directed bench for mac_window_accum: WINDOW=8 instance plus a WINDOW=1 instance.
module tb_mac_window_accum;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sum;
  logic        out_sat;

  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] in_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic [17:0] out_sum1;
  logic        out_sat1;

  int tests_run;
  int tests_failed;

  mac_window_accum #(.IN_W(16), .WINDOW(8), .ACC_W(18)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  mac_window_accum #(.IN_W(16), .WINDOW(1), .ACC_W(18)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_sat   (out_sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic push(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push_n(input int count, input logic [15:0] d);
    for (int i = 0; i < count; i++) push(d);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_data1   = '0;
    out_ready1 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_w1_out_valid", 32'(out_valid1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset mid-window discards the partial sum
    push_n(5, 16'h0010);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t1_valid_in_reset", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t1_valid_after_reset", 32'(out_valid), 32'd0);
    push_n(8, 16'h0001);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(out_sum), 32'd8);
    check("t1_sat", 32'(out_sat), 32'd0);
    @(posedge clk);
    #1;

    // 2: basic window, one-cycle latency, single-cycle pulse
    push_n(7, 16'd100);
    check("t2_valid_before_last", 32'(out_valid), 32'd0);
    push(16'd100);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_sum", 32'(out_sum), 32'd800);
    check("t2_sat", 32'(out_sat), 32'd0);
    @(posedge clk);
    #1;
    check("t2_valid_drop", 32'(out_valid), 32'd0);
    check("t2_sum_held", 32'(out_sum), 32'd800);

    // 3: saturation, then flag clears on the next window
    push_n(8, 16'hFFFF);
    check("t3_sum_sat", 32'(out_sum), 32'h3FFFF);
    check("t3_sat", 32'(out_sat), 32'd1);
    @(posedge clk);
    #1;
    push_n(8, 16'h0001);
    check("t3_sum_after", 32'(out_sum), 32'd8);
    check("t3_sat_cleared", 32'(out_sat), 32'd0);
    @(posedge clk);
    #1;

    // 4: backpressure stalls only the completing sample
    out_ready = 1'b0;
    push_n(8, 16'd100);
    check("t4_first_valid", 32'(out_valid), 32'd1);
    check("t4_first_sum", 32'(out_sum), 32'd800);
    push_n(7, 16'd5);
    check("t4_pending_sum", 32'(out_sum), 32'd800);
    in_valid = 1'b1;
    in_data  = 16'd5;
    #1;
    check("t4_stall", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_stall_hold", 32'(in_ready), 32'd0);
    check("t4_hold_sum", 32'(out_sum), 32'd800);
    check("t4_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check("t4_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t4_second_valid", 32'(out_valid), 32'd1);
    check("t4_second_sum", 32'(out_sum), 32'd40);
    check("t4_second_sat", 32'(out_sat), 32'd0);
    @(posedge clk);
    #1;
    check("t4_drain", 32'(out_valid), 32'd0);

    // 5: clr drops the concurrent sample and leaves the pending total alone
    out_ready = 1'b0;
    push_n(8, 16'd2);
    check("t5_pending_valid", 32'(out_valid), 32'd1);
    check("t5_pending_sum", 32'(out_sum), 32'd16);
    push_n(3, 16'd7);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd9;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("t5_clr_valid", 32'(out_valid), 32'd1);
    check("t5_clr_sum", 32'(out_sum), 32'd16);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_taken", 32'(out_valid), 32'd0);
    push_n(7, 16'd5);
    check("t5_no_early", 32'(out_valid), 32'd0);
    push(16'd5);
    check("t5_sum", 32'(out_sum), 32'd40);
    check("t5_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // 6: WINDOW=1 produces a total per accepted sample
    for (int i = 3; i <= 5; i++) begin
      in_valid1 = 1'b1;
      in_data1  = 16'(i);
      #1;
      check("t6_in_ready", 32'(in_ready1), 32'd1);
      @(posedge clk);
      #1;
      check("t6_valid", 32'(out_valid1), 32'd1);
      check("t6_sum", 32'(out_sum1), 32'(i));
    end
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    check("t6_drain", 32'(out_valid1), 32'd0);
    check("t6_sat", 32'(out_sat1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
